gcd_operand_sequencer: RTL and testbench
========================================

# gcd_operand_sequencer

Front-end stage for the subtractive GCD unit. It accepts operand pairs over a valid/ready stream and presents X then Y on the shared operand bus with the `load` strobe the GCD controller expects. It waits for the controller's `done`, then returns the result and an iteration count over a second valid/ready stream. Zero operands, which never terminate in the subtractive loop, are resolved locally and never issued to the controller.

## Interface
- `WIDTH`, 16: operand and result width.
- `CNT_W`, 8: width of the iteration counter.
- `clock` in 1: single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-low; the top level drives the controller's reset from the same source.
- `in_valid` in 1: operand pair is valid.
- `in_ready` out 1: sequencer accepts a pair.
- `in_x`, `in_y` in WIDTH: operands.
- `load` out 1: to the controller's `load` input.
- `operand` out WIDTH: shared data bus into the datapath X/Y input mux.
- `done` in 1: from the controller.
- `result` in WIDTH: datapath X register.
- `out_valid` out 1; `out_ready` in 1: result handshake.
- `out_gcd` out WIDTH: GCD result.
- `out_cycles` out CNT_W: number of compare/subtract cycles used.
- `out_error` out 1: set when both operands are zero.

## Operation
States are IDLE, SEND_X, SEND_Y, WAIT, HOLD.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch x, y and clear the counter.
  - If both operands are nonzero, go to SEND_X.
  - If exactly one is zero, go to HOLD with `out_gcd`=the nonzero operand, `out_cycles`=0, `out_error`=0.
  - If both are zero, go to HOLD with `out_gcd`=0, `out_cycles`=0, `out_error`=1.
- **SEND_X**: `load`=1, `operand`=x. Next state SEND_Y.
- **SEND_Y**: `load`=0, `operand`=y. Next state WAIT.
- **WAIT**
  - `operand`=0.
  - The counter increments each cycle, saturating at 2^CNT_W−1.
  - On `done`=1: capture `result` into `out_gcd` and go to HOLD. The count includes the `done` cycle.
  - `done` is sampled only in WAIT. A stale `done` from the controller's done state, seen in IDLE, SEND_X or HOLD, is ignored.
- **HOLD**
  - `out_valid`=1; `out_gcd`, `out_cycles` and `out_error` stay stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0 in HOLD, so there is no overlap with the next pair.
- `load`, `operand`, `in_ready` and `out_valid` are decoded from the state register only (Moore outputs). They have no combinational path from inputs.

## Timing
- While `reset` is low, asynchronously:
  - state goes to IDLE;
  - `load`=0, `operand`=0, `in_ready`=0, `out_valid`=0;
  - `out_gcd`=0, `out_cycles`=0, `out_error`=0.
- `in_ready` is 1 from the first cycle after `reset` is released.
- Issuing a pair (acceptance at edge N):
  - `load`/x appear in cycle N+1 and y in cycle N+2.
  - The controller samples both in those cycles: it captures X in its idle/done state and Y in its load state.
- Result latency:
  - Nonzero pair: `out_valid` rises 3 + k cycles after acceptance, where k is the WAIT cycle count (k ≥ 1).
  - Zero bypass: 1 cycle after acceptance.
- Reset asserted mid-operation, in any state: abort immediately and discard the pair; nothing is output for it.
- `out_cycles` saturates and does not wrap. The GCD result is still returned correctly.
- `in_valid` and `out_ready` may both be high in HOLD: the result completes and the state returns to IDLE. The new pair is accepted no earlier than the following edge.

## Structure
- Shared package `gcd_pkg`:
  - typedef `seq_state_t` (enum logic [2:0]: IDLE, SEND_X, SEND_Y, WAIT, HOLD);
  - constant `GCD_WIDTH`=16, used as the default for `WIDTH`.
- One sub-module, `sat_counter` (parameter `W`; ports clear, enable, count), instantiated for the WAIT cycle count.
- The rest is one state register process plus output decode.

## Test plan
- (12,18) with the controller and datapath attached: one `load` pulse, `operand` 12 then 18 → `out_gcd`=6, `out_cycles`=3, `out_error`=0.
- (7,7): `done` in the first WAIT cycle → `out_gcd`=7, `out_cycles`=1, `out_valid` 4 cycles after acceptance.
- (0,9), then (9,0) → `out_gcd`=9, `out_cycles`=0, `load` never asserted, `out_valid` 1 cycle after acceptance. (0,0) → `out_gcd`=0, `out_error`=1.
- (12,18) with `out_ready` held low 5 cycles → outputs stable, `in_ready`=0 throughout. A pair (21,14) presented meanwhile is accepted only after the handshake, then → 7.
- `reset` low during WAIT of (1000,1) → all outputs 0 immediately, no result emitted. A following (8,12) → 4.
- CNT_W=2 with (1,10) → `out_gcd`=1, `out_cycles`=3 (saturated).

Source files
------------

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and defaults for the GCD front-end
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEND_X,
        SEND_Y,
        WAIT,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// rtl/gcd_operand_sequencer.sv - issues operand pairs to the GCD controller and returns results
module gcd_operand_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             load,
    output logic [WIDTH-1:0] operand,
    input  logic             done,
    input  logic [WIDTH-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_cycles,
    output logic             out_error
);

    seq_state_t       state;
    logic [WIDTH-1:0] y_q;
    logic             accept;
    logic             x_zero;
    logic             y_zero;

    assign accept = in_valid && in_ready;
    assign x_zero = (in_x == '0);
    assign y_zero = (in_y == '0);

    // Cleared on every accepted pair, so a zero bypass reports 0 cycles.
    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state == WAIT),
        .count  (out_cycles)
    );

    // Outputs are registered alongside the next state so they track the
    // state register exactly, with no combinational path from inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            load      <= 1'b0;
            operand   <= '0;
            out_valid <= 1'b0;
            out_gcd   <= '0;
            out_error <= 1'b0;
            y_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        y_q       <= in_y;
                        in_ready  <= 1'b0;
                        out_error <= 1'b0;
                        if (!x_zero && !y_zero) begin
                            state   <= SEND_X;
                            load    <= 1'b1;
                            operand <= in_x;
                        end else begin
                            // Zero operands never terminate in the subtractive loop.
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_gcd   <= x_zero ? in_y : in_x;
                            out_error <= x_zero && y_zero;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SEND_X: begin
                    state   <= SEND_Y;
                    load    <= 1'b0;
                    operand <= y_q;
                end
                SEND_Y: begin
                    state   <= WAIT;
                    operand <= '0;
                end
                WAIT: begin
                    if (done) begin
                        state     <= HOLD;
                        out_gcd   <= result;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    load      <= 1'b0;
                    operand   <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// tb/tb_gcd_operand_sequencer.sv - scoreboard bench with controller models, CNT_W=8 and CNT_W=2
module tb_gcd_operand_sequencer;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [15:0]      in_x;
    logic [15:0]      in_y;
    logic             out_ready;

    logic [1:0]       in_ready_v;
    logic [1:0]       load_v;
    logic [1:0]       done_v;
    logic [1:0]       out_valid_v;
    logic [1:0]       out_error_v;
    logic [1:0][15:0] operand_v;
    logic [1:0][15:0] result_v;
    logic [1:0][15:0] out_gcd_v;
    logic [1:0][7:0]  cycles_v;

    always #5 clock = ~clock;

    // Instance 0 uses CNT_W=8, instance 1 uses CNT_W=2; both get the same stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CW = (g == 0) ? 8 : 2;
        logic [CW-1:0] cyc;
        logic [15:0]   cx;
        logic [15:0]   cy;
        logic [1:0]    ph;

        assign done_v[g]   = ((ph == 2'd2) && (cx == cy)) || (ph == 2'd3);
        assign result_v[g] = cx;
        assign cycles_v[g] = 8'(cyc);

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                ph <= 2'd0;
                cx <= 16'd0;
                cy <= 16'd0;
            end else if (load_v[g]) begin
                cx <= operand_v[g];
                ph <= 2'd1;
            end else if (ph == 2'd1) begin
                cy <= operand_v[g];
                ph <= 2'd2;
            end else if (ph == 2'd2) begin
                if (cx == cy)     ph <= 2'd3;
                else if (cx > cy) cx <= cx - cy;
                else              cy <= cy - cx;
            end
        end

        gcd_operand_sequencer #(.WIDTH(16), .CNT_W(CW)) u_dut (
            .clock      (clock),
            .reset      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready_v[g]),
            .in_x       (in_x),
            .in_y       (in_y),
            .load       (load_v[g]),
            .operand    (operand_v[g]),
            .done       (done_v[g]),
            .result     (result_v[g]),
            .out_valid  (out_valid_v[g]),
            .out_ready  (out_ready),
            .out_gcd    (out_gcd_v[g]),
            .out_cycles (cyc),
            .out_error  (out_error_v[g])
        );
    end

    typedef struct {
        int x;
        int y;
        int g;
        int c;
        int e;
        int zero;
        int acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hold_low = 0;
    bit   aborting = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Euclid by division: the subtractive loop spends one cycle per unit of
    // quotient, the last of which is the cycle that raises done.
    function automatic exp_t ref_model(input int x, input int y);
        exp_t r;
        int   a, b, t;
        r.x = x; r.y = y; r.c = 0; r.e = 0; r.acc = 0;
        r.zero = (x == 0 || y == 0) ? 1 : 0;
        if (x == 0 && y == 0) begin
            r.g = 0; r.e = 1;
        end else if (x == 0) begin
            r.g = y;
        end else if (y == 0) begin
            r.g = x;
        end else begin
            a = x; b = y;
            while (b != 0) begin
                r.c += a / b;
                t = a % b;
                a = b;
                b = t;
            end
            r.g = a;
        end
        return r;
    endfunction

    task automatic send(input int x, input int y, input bit push);
        int   n;
        exp_t r;
        n = 0;
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_x = 16'(x);
        in_y = 16'(y);
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready_v[0] && n < 4000);
        if (!in_ready_v[0]) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (push) begin
            r = ref_model(x, y);
            r.acc = cyc;
            q.push_back(r);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(posedge clock);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            check({tag, "_in_ready"},  int'(in_ready_v[g]), 0);
            check({tag, "_load"},      int'(load_v[g]), 0);
            check({tag, "_operand"},   int'(operand_v[g]), 0);
            check({tag, "_out_valid"}, int'(out_valid_v[g]), 0);
            check({tag, "_out_gcd"},   int'(out_gcd_v[g]), 0);
            check({tag, "_cycles"},    int'(cycles_v[g]), 0);
            check({tag, "_error"},     int'(out_error_v[g]), 0);
        end
    endtask

    task automatic abort_run(input int x, input int y);
        wait_idle();
        aborting = 1'b1;
        send(x, y, 1'b0);
        repeat (6) @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        aborting = 1'b0;
        @(negedge clock);
        check("abort_in_ready_after", int'(in_ready_v[0]), 1);
    endtask

    // out_ready: random, except for a forced run of low cycles while valid.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (out_valid_v[0] && hold_low > 0) begin
                out_ready = 1'b0;
                hold_low--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        exp_t e;
        int   load_cnt[2];
        bit   chk_y[2];
        bit   prev_valid;
        load_cnt = '{0, 0};
        chk_y = '{1'b0, 1'b0};
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                load_cnt = '{0, 0};
                chk_y = '{1'b0, 1'b0};
                prev_valid = 1'b0;
            end else begin
                for (int g = 0; g < 2; g++) begin
                    if (load_v[g]) begin
                        if (!aborting) begin
                            if (q.size() == 0) begin
                                check("load_unexpected", 1, 0);
                            end else begin
                                check("load_operand_x", int'(operand_v[g]), q[0].x);
                                load_cnt[g]++;
                                chk_y[g] = 1'b1;
                            end
                        end
                    end else if (chk_y[g]) begin
                        if (q.size() != 0) check("operand_y", int'(operand_v[g]), q[0].y);
                        chk_y[g] = 1'b0;
                    end
                end
                if (out_valid_v != 2'b00) begin
                    check("out_valid_match", int'(out_valid_v[1]), int'(out_valid_v[0]));
                end
                if (out_valid_v[0]) begin
                    if (q.size() == 0) begin
                        check("spurious_output", 1, 0);
                    end else begin
                        e = q[0];
                        check("gcd_w8", int'(out_gcd_v[0]), e.g);
                        check("gcd_w2", int'(out_gcd_v[1]), e.g);
                        check("cycles_w8", int'(cycles_v[0]), (e.c < 255) ? e.c : 255);
                        check("cycles_w2", int'(cycles_v[1]), (e.c < 3) ? e.c : 3);
                        check("error_w8", int'(out_error_v[0]), e.e);
                        check("error_w2", int'(out_error_v[1]), e.e);
                        check("in_ready_hold", int'(in_ready_v[0] | in_ready_v[1]), 0);
                        if (!prev_valid) begin
                            check("latency", cyc + 1 - e.acc, (e.zero != 0) ? 1 : 3 + e.c);
                        end
                        if (out_ready) begin
                            check("load_pulses_w8", load_cnt[0], (e.zero != 0) ? 0 : 1);
                            check("load_pulses_w2", load_cnt[1], (e.zero != 0) ? 0 : 1);
                            load_cnt = '{0, 0};
                            void'(q.pop_front());
                        end
                    end
                end
                prev_valid = out_valid_v[0];
            end
        end
    end

    initial begin
        int x, y;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_x     = 16'd0;
        in_y     = 16'd0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        check("in_ready_at_release", int'(in_ready_v[0]), 0);
        @(negedge clock);
        check("in_ready_after_release", int'(in_ready_v[0]), 1);
        check("in_ready_after_release_w2", int'(in_ready_v[1]), 1);

        send(12, 18, 1'b1);
        send(7, 7, 1'b1);
        send(0, 9, 1'b1);
        send(9, 0, 1'b1);
        send(0, 0, 1'b1);
        wait_idle();
        hold_low = 5;
        send(12, 18, 1'b1);
        send(21, 14, 1'b1);
        send(1, 10, 1'b1);
        send(1, 300, 1'b1);
        abort_run(1000, 1);
        send(8, 12, 1'b1);

        for (int i = 0; i < 60; i++) begin
            x = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 255));
            y = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 255));
            send(x, y, 1'b1);
        end

        wait_idle();
        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
